reg_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single write port between R independent writeback requesters, such as the ALU result path and the switch/immediate load path. It sits between the writeback sources and the register file. It accepts at most one write per cycle through a valid/ready handshake and drives the register file's write address, data and enable from a registered output stage. Writes to register 0 are accepted but never issued.

---
 rtl/reg_wr_arbiter_if.sv | 31 +++
 rtl/reg_wr_arbiter.sv | 82 ++++++++
 tb/tb_reg_wr_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_if.sv
// Writeback bus between the requesters, the write-port arbiter and the register file.
// Request fields are packed per requester; the write stage feeds the register file.
interface reg_wr_arbiter_if #(
  parameter int unsigned R = 2,
  parameter int unsigned M = 32,
  parameter int unsigned N = 8
);
  localparam int unsigned ADDR_SZ = $clog2(M);
  localparam int unsigned GW      = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]         req_valid;
  logic [R*ADDR_SZ-1:0] req_addr;
  logic [R*N-1:0]       req_data;
  logic [R-1:0]         req_ready;
  logic [ADDR_SZ-1:0]   wr_addr;
  logic [N-1:0]         wr_data;
  logic                 wr_en;
  logic [GW-1:0]        last_grant;

  // Environment side: requesters plus the register file write port.
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_addr, wr_data, wr_en, last_grant
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_addr, wr_data, wr_en, last_grant
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among R writeback
// requesters; one registered write per cycle, register-0 writes are accepted but not issued.
module reg_wr_arbiter #(
  parameter int unsigned R = 2,
  parameter int unsigned M = 32,
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  reg_wr_arbiter_if.slave bus
);
  localparam int unsigned ADDR_SZ = $clog2(M);
  localparam int unsigned GW      = (R > 1) ? $clog2(R) : 1;

  logic [GW-1:0]      ptr_q;
  logic [GW-1:0]      last_q;
  logic [ADDR_SZ-1:0] wr_addr_q;
  logic [N-1:0]       wr_data_q;
  logic               wr_en_q;

  logic [GW-1:0]      idx;
  logic [GW-1:0]      gnt_idx;
  logic               found;
  logic [R-1:0]       grant;
  logic [ADDR_SZ-1:0] sel_addr;
  logic [N-1:0]       sel_data;

  // Rotating priority scan starting at ptr; first valid requester wins.
  always_comb begin
    idx      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    grant    = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = GW'((32'(ptr_q) + k) % R);
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (hold || reset) begin
      found = 1'b0;
    end
    if (found) begin
      grant[gnt_idx] = 1'b1;
    end
    for (int unsigned i = 0; i < R; i++) begin
      if (GW'(i) == gnt_idx) begin
        sel_addr = bus.req_addr[i*ADDR_SZ +: ADDR_SZ];
        sel_data = bus.req_data[i*N +: N];
      end
    end
  end

  // Output stage and pointer; wr_en pulses once per accepted non-zero-address write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      last_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else if (found) begin
      wr_addr_q <= sel_addr;
      wr_data_q <= sel_data;
      wr_en_q   <= (sel_addr != '0);
      last_q    <= gnt_idx;
      ptr_q     <= (gnt_idx == GW'(R - 1)) ? '0 : gnt_idx + GW'(1);
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.last_grant = last_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios then random traffic, checked every cycle
// against an integer-level round-robin model and a modelled register file.
module tb_reg_wr_arbiter;
  localparam int unsigned R  = 2;
  localparam int unsigned M  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = $clog2(M);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic hold  = 1'b0;

  always #5 clk = ~clk;

  reg_wr_arbiter_if #(.R(R), .M(M), .N(N)) bus ();

  reg_wr_arbiter #(.R(R), .M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus applied at the next falling edge.
  bit          rst_d  = 1'b1;
  bit          hold_d = 1'b0;
  bit          v[R];
  int unsigned a[R];
  int unsigned d[R];

  // Reference model state.
  int          m_ptr  = 0;
  int          m_last = 0;
  int unsigned m_addr = 0;
  int unsigned m_data = 0;
  bit          m_en   = 1'b0;
  int unsigned ref_rf[M];
  int unsigned rf[M];
  int          g_now  = -1;
  int          wait_cnt[R];

  logic [31:0] obs_ready, obs_en, obs_addr, obs_data, obs_last, obs_ptr;

  // Register file behind the write port (writes any address it is told to).
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) rf[bus.wr_addr] <= 32'(bus.wr_data);
  end

  function automatic int model_grant();
    if (rst_d || hold_d) return -1;
    for (int k = 0; k < int'(R); k++) begin
      int j;
      j = (m_ptr + k) % int'(R);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic run_cycle();
    int g;
    @(negedge clk);
    reset = rst_d;
    hold  = hold_d;
    for (int i = 0; i < int'(R); i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_addr[i*AW +: AW]   = AW'(a[i]);
      bus.req_data[i*N +: N]     = N'(d[i]);
    end
    #1;
    g = model_grant();
    obs_ready = 32'(bus.req_ready);
    obs_en    = 32'(bus.wr_en);
    obs_addr  = 32'(bus.wr_addr);
    obs_data  = 32'(bus.wr_data);
    obs_last  = 32'(bus.last_grant);
    obs_ptr   = 32'(dut.ptr_q);
    check("req_ready", obs_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    check("wr_en", obs_en, 32'(m_en));
    check("wr_addr", obs_addr, m_addr);
    check("wr_data", obs_data, m_data);
    check("last_grant", obs_last, 32'(m_last));
    check("ptr", obs_ptr, 32'(m_ptr));
    @(posedge clk);
    if (m_en) ref_rf[m_addr] = m_data;
    if (rst_d) begin
      m_ptr = 0; m_last = 0; m_addr = 0; m_data = 0; m_en = 1'b0;
    end else if (g >= 0) begin
      m_addr = a[g];
      m_data = d[g];
      m_en   = (a[g] != 0);
      m_last = g;
      m_ptr  = (g + 1) % int'(R);
    end else begin
      m_en = 1'b0;
    end
    g_now = g;
  endtask

  initial begin
    for (int i = 0; i < int'(R); i++) begin
      v[i] = 1'b0; a[i] = 0; d[i] = 0; wait_cnt[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset with both requesters pending, then round-robin release.
    rst_d = 1'b1;
    v[0] = 1'b1; a[0] = 3; d[0] = 8'hA1;
    v[1] = 1'b1; a[1] = 4; d[1] = 8'hB2;
    repeat (2) begin
      run_cycle();
      check("rst_ready", obs_ready, 0);
      check("rst_wr_en", obs_en, 0);
      check("rst_wr_data", obs_data, 0);
    end
    rst_d = 1'b0;
    run_cycle();
    check("rr_first", obs_ready, 1);
    v[0] = 1'b0;
    run_cycle();
    check("rr_second", obs_ready, 2);
    v[1] = 1'b0;
    run_cycle();

    // Single requester.
    v[1] = 1'b1; a[1] = 5; d[1] = 8'h3C;
    run_cycle();
    check("single_gnt", obs_ready, 2);
    v[1] = 1'b0;
    run_cycle();
    check("single_en", obs_en, 1);
    check("single_addr", obs_addr, 5);
    check("single_data", obs_data, 8'h3C);
    check("single_last", obs_last, 1);
    check("single_ptr", obs_ptr, 0);

    // Contention on the same address.
    a[0] = 3; d[0] = 8'h11; a[1] = 3; d[1] = 8'h22;
    for (int k = 0; k < 5; k++) begin
      v[0] = (k < 4); v[1] = (k < 4);
      run_cycle();
      if (k < 4) check("cont_gnt", obs_ready, 32'd1 << (k % 2));
      if (k > 0) check("cont_data", obs_data, (k % 2 == 1) ? 32'h11 : 32'h22);
    end
    run_cycle();
    check("cont_rf3", rf[3], 8'h22);

    // Address 0: handshake completes, no write issued.
    v[0] = 1'b1; a[0] = 0; d[0] = 8'hFF;
    run_cycle();
    check("a0_ready", obs_ready, 1);
    v[0] = 1'b0;
    run_cycle();
    check("a0_wr_en", obs_en, 0);
    check("a0_ptr", obs_ptr, 1);

    // Hold with a write in flight.
    v[0] = 1'b1; a[0] = 7; d[0] = 8'h5A;
    run_cycle();
    a[0] = 8; d[0] = 8'h66;
    hold_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      check("hold_ready", obs_ready, 0);
      check("hold_wr_en", obs_en, (k == 0) ? 32'd1 : 32'd0);
    end
    hold_d = 1'b0;
    run_cycle();
    check("hold_release", obs_ready, 1);
    v[0] = 1'b0;
    run_cycle();

    // Reset right after an accepted write.
    v[1] = 1'b1; a[1] = 9; d[1] = 8'h77;
    run_cycle();
    check("rstmid_gnt", obs_ready, 2);
    v[1] = 1'b0; rst_d = 1'b1;
    run_cycle();
    rst_d = 1'b0;
    v[0] = 1'b1; a[0] = 10; d[0] = 8'h01;
    v[1] = 1'b1; a[1] = 11; d[1] = 8'h02;
    run_cycle();
    check("rstmid_en", obs_en, 0);
    check("rstmid_ptr", obs_ptr, 0);
    check("rstmid_gnt0", obs_ready, 1);
    v[0] = 1'b0; v[1] = 1'b0;
    run_cycle();

    // Random traffic with hold, occasional reset and a fairness bound.
    for (int c = 0; c < 400; c++) begin
      rst_d  = ($urandom_range(0, 49) == 0);
      hold_d = ($urandom_range(0, 6) == 0);
      run_cycle();
      for (int i = 0; i < int'(R); i++) begin
        if (rst_d) begin
          wait_cnt[i] = 0;
        end else if (v[i] && g_now == i) begin
          check("fairness", 32'(wait_cnt[i] < int'(R)), 1);
          wait_cnt[i] = 0;
        end else if (v[i] && !hold_d) begin
          wait_cnt[i]++;
        end
        if ((v[i] && g_now == i) || !v[i]) begin
          v[i] = ($urandom_range(0, 1) == 1);
          a[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
          d[i] = $urandom_range(0, 255);
        end
      end
    end

    rst_d = 1'b0; hold_d = 1'b0;
    for (int i = 0; i < int'(R); i++) v[i] = 1'b0;
    repeat (3) run_cycle();
    check("rf0_zero", rf[0], 0);
    for (int r = 0; r < int'(M); r++) check("rf_final", rf[r], ref_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
